// File: rtl/accel_pwm_command_pkg.sv
// Shared widths, FSM encoding and the level-to-duty mapping for the accelerometer
// to PWM command path.
package accel_pwm_command_pkg;

    localparam int SAMPLE_W = 12;
    localparam int CMD_W    = 10;
    localparam int WIN_LOG2 = 3;
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int SUM_W    = SAMPLE_W + WIN_LOG2;
    localparam int LEVEL_W  = SAMPLE_W + 1;
    localparam int CMD_MAX  = (1 << CMD_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SUM    = 2'd1,
        ST_TARGET = 2'd2
    } avg_state_t;

    // Done in 32-bit arithmetic so the shifted excess can never wrap before the clamp.
    function automatic logic [CMD_W-1:0] level_to_target(
        input logic signed [LEVEL_W-1:0] level,
        input int                        deadband,
        input int                        gain_shift
    );
        int excess;
        int scaled;
        excess = int'(level) - deadband;
        if (excess <= 0) begin
            return '0;
        end
        scaled = excess << gain_shift;
        if (scaled > CMD_MAX) begin
            return CMD_W'(CMD_MAX);
        end
        return CMD_W'(scaled);
    endfunction

endpackage

// File: rtl/accel_pwm_command_slew_limiter.sv
// Moves the duty command toward the target by bounded steps on each slew tick;
// BRAKE forces the command to zero.
module accel_pwm_command_slew_limiter
    import accel_pwm_command_pkg::*;
#(
    parameter int RAMP_UP   = 4,
    parameter int RAMP_DOWN = 16
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [CMD_W-1:0] target,
    input  logic             tick,
    input  logic             BRAKE,
    output logic [CMD_W-1:0] PWMinput
);

    logic [CMD_W-1:0] up_gap;
    logic [CMD_W-1:0] down_gap;
    logic [CMD_W-1:0] up_step;
    logic [CMD_W-1:0] down_step;

    // Each step is capped by the remaining gap, so the command lands exactly on target.
    always_comb begin
        up_gap    = target - PWMinput;
        down_gap  = PWMinput - target;
        up_step   = (up_gap > CMD_W'(RAMP_UP)) ? CMD_W'(RAMP_UP) : up_gap;
        down_step = (down_gap > CMD_W'(RAMP_DOWN)) ? CMD_W'(RAMP_DOWN) : down_gap;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            PWMinput <= '0;
        end else if (BRAKE) begin
            PWMinput <= '0;
        end else if (tick) begin
            if (PWMinput < target) begin
                PWMinput <= PWMinput + up_step;
            end else if (PWMinput > target) begin
                PWMinput <= PWMinput - down_step;
            end
        end
    end

endmodule

// File: rtl/accel_pwm_command.sv
// Accelerometer sample to motor duty command: 8-tap moving average, zero-g offset,
// deadband, gain with clamp, then slew limiting toward the PWM generator.
module accel_pwm_command
    import accel_pwm_command_pkg::*;
#(
    parameter int ZERO_G     = 0,
    parameter int DEADBAND   = 16,
    parameter int GAIN_SHIFT = 1,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_UP    = 4,
    parameter int RAMP_DOWN  = 16
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [11:0] ACCELdata,
    input  logic        ACCELvalid,
    input  logic        BRAKE,
    output logic [9:0]  PWMinput,
    output logic        TARGETvalid,
    output logic        SAMPLEdrop
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RAMP_DIV - 1);
    localparam logic [WIN_LOG2:0]   FILL_FULL = (WIN_LOG2 + 1)'(WIN);

    avg_state_t                  state;
    avg_state_t                  state_next;
    logic signed [SAMPLE_W-1:0]  win_buf [WIN];
    logic signed [SAMPLE_W-1:0]  new_sample;
    logic signed [SAMPLE_W-1:0]  oldest;
    logic signed [SUM_W-1:0]     sum;
    logic [WIN_LOG2-1:0]         wr_ptr;
    logic [WIN_LOG2:0]           fill;
    logic [CMD_W-1:0]            target;
    logic [CMD_W-1:0]            target_next;
    logic signed [LEVEL_W-1:0]   level;
    logic [CNT_W-1:0]            tick_cnt;
    logic                        tick;

    // ACCELvalid is a one-cycle strobe with no back-pressure: a sample is taken only
    // in IDLE; one arriving while SUM/TARGET run is discarded and flagged on SAMPLEdrop.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (ACCELvalid) state_next = ST_SUM;
            ST_SUM:    state_next = ST_TARGET;
            ST_TARGET: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Negative tilt falls below the deadband inside the mapping, so it yields 0.
    always_comb begin
        level       = LEVEL_W'(sum >>> WIN_LOG2) - LEVEL_W'(ZERO_G);
        target_next = (fill == FILL_FULL) ? level_to_target(level, DEADBAND, GAIN_SHIFT) : '0;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < WIN; i++) begin
                win_buf[i] <= '0;
            end
            new_sample  <= '0;
            oldest      <= '0;
            sum         <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            target      <= '0;
            TARGETvalid <= 1'b0;
            SAMPLEdrop  <= 1'b0;
        end else begin
            TARGETvalid <= 1'b0;
            SAMPLEdrop  <= ACCELvalid && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (ACCELvalid) begin
                        new_sample <= $signed(ACCELdata);
                        oldest     <= win_buf[wr_ptr];
                    end
                end
                ST_SUM: begin
                    sum             <= sum + SUM_W'(new_sample) - SUM_W'(oldest);
                    win_buf[wr_ptr] <= new_sample;
                    wr_ptr          <= wr_ptr + WIN_LOG2'(1);
                    if (fill != FILL_FULL) begin
                        fill <= fill + (WIN_LOG2 + 1)'(1);
                    end
                end
                ST_TARGET: begin
                    target      <= target_next;
                    TARGETvalid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Slew tick divider; held at 0 while braking so the ramp restarts cleanly.
    assign tick = !BRAKE && (tick_cnt == CNT_LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            tick_cnt <= '0;
        end else if (BRAKE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    accel_pwm_command_slew_limiter #(
        .RAMP_UP   (RAMP_UP),
        .RAMP_DOWN (RAMP_DOWN)
    ) u_slew (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .target   (target),
        .tick     (tick),
        .BRAKE    (BRAKE),
        .PWMinput (PWMinput)
    );

endmodule
